// File: rtl/alu_unit_pkg.sv
// Shared types and op encoding for the integer execution unit, decoder and
// reservation station.
package alu_unit_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ROB_WIDTH  = 4;
  localparam int OP_WIDTH   = 6;

  typedef logic [DATA_WIDTH-1:0] DATA_TYPE;
  typedef logic [DATA_WIDTH-1:0] ADDR_TYPE;
  typedef logic [ROB_WIDTH-1:0]  ROB_INDEX_TYPE;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Encodings 0 and 30..63 are unused and execute as "unknown op".
  typedef enum logic [OP_WIDTH-1:0] {
    OP_NONE  = 6'd0,
    OP_LUI   = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,  OP_JALR  = 6'd4,
    OP_BEQ   = 6'd5,  OP_BNE   = 6'd6,  OP_BLT   = 6'd7,  OP_BGE   = 6'd8,
    OP_BLTU  = 6'd9,  OP_BGEU  = 6'd10,
    OP_ADDI  = 6'd11, OP_SLTI  = 6'd12, OP_SLTIU = 6'd13, OP_XORI  = 6'd14,
    OP_ORI   = 6'd15, OP_ANDI  = 6'd16, OP_SLLI  = 6'd17, OP_SRLI  = 6'd18,
    OP_SRAI  = 6'd19,
    OP_ADD   = 6'd20, OP_SUB   = 6'd21, OP_SLL   = 6'd22, OP_SLT   = 6'd23,
    OP_SLTU  = 6'd24, OP_XOR   = 6'd25, OP_SRL   = 6'd26, OP_SRA   = 6'd27,
    OP_OR    = 6'd28, OP_AND   = 6'd29
  } OPENUM_TYPE;

  function automatic logic usesPcAsA(input logic [OP_WIDTH-1:0] op);
    logic sel;
    sel = (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR);
    return sel;
  endfunction

  function automatic logic usesImmAsB(input logic [OP_WIDTH-1:0] op);
    logic sel;
    case (op)
      OP_LUI, OP_AUIPC, OP_JALR, OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI,
      OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI: sel = TRUE;
      default:                                    sel = FALSE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_branch_cmp.sv
// Combinational branch condition evaluator; taken_o is low for non-branch ops.
module alu_branch_cmp
  import alu_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
) (
  input  logic [DATA_W-1:0] rs1_i,
  input  logic [DATA_W-1:0] rs2_i,
  input  logic [OP_W-1:0]   op_i,
  output logic              taken_o
);

  always_comb begin
    taken_o = FALSE;
    case (op_i)
      OP_BEQ:  taken_o = (rs1_i == rs2_i);
      OP_BNE:  taken_o = (rs1_i != rs2_i);
      OP_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
      OP_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
      OP_BLTU: taken_o = (rs1_i <  rs2_i);
      OP_BGEU: taken_o = (rs1_i >= rs2_i);
      default: taken_o = FALSE;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// Two-stage pipelined RV32I integer execution unit driving the ALU result bus.
// S1 registers the muxed operands, S2 computes and registers the broadcast.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4,
  parameter int OP_W   = 6
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clr_in,
  input  logic              rs_to_alu_ready,
  input  logic [OP_W-1:0]   rs_to_alu_op,
  input  logic [DATA_W-1:0] rs_to_alu_rs1,
  input  logic [DATA_W-1:0] rs_to_alu_rs2,
  input  logic [ROB_W-1:0]  rs_to_alu_rob_index,
  input  logic [DATA_W-1:0] rs_to_alu_PC,
  input  logic [DATA_W-1:0] rs_to_alu_imm,
  output logic              alu_ready,
  output logic [DATA_W-1:0] alu_result,
  output logic [ROB_W-1:0]  alu_rob_index,
  output logic              alu_jump,
  output logic [DATA_W-1:0] alu_target_PC
);

  logic              s1Valid_q;
  logic [OP_W-1:0]   s1Op_q;
  logic [ROB_W-1:0]  s1Rob_q;
  logic [DATA_W-1:0] s1Pc_q;
  logic [DATA_W-1:0] s1Imm_q;
  logic [DATA_W-1:0] s1A_q;
  logic [DATA_W-1:0] s1B_q;
  logic [DATA_W-1:0] s1Rs1_q;
  logic [DATA_W-1:0] s1Rs2_q;
  logic [DATA_W-1:0] s1A_d;
  logic [DATA_W-1:0] s1B_d;

  logic              branchTaken;
  logic [DATA_W-1:0] result_d;
  logic              jump_d;
  logic [DATA_W-1:0] target_d;

  logic              s2Ready_q;
  logic [DATA_W-1:0] s2Result_q;
  logic [ROB_W-1:0]  s2Rob_q;
  logic              s2Jump_q;
  logic [DATA_W-1:0] s2Target_q;

  assign s1A_d = usesPcAsA(rs_to_alu_op)  ? rs_to_alu_PC  : rs_to_alu_rs1;
  assign s1B_d = usesImmAsB(rs_to_alu_op) ? rs_to_alu_imm : rs_to_alu_rs2;

  // Flush beats the global stall so a misprediction is never held off.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1Valid_q <= FALSE;
      s1Op_q    <= '0;
      s1Rob_q   <= '0;
      s1Pc_q    <= '0;
      s1Imm_q   <= '0;
      s1A_q     <= '0;
      s1B_q     <= '0;
      s1Rs1_q   <= '0;
      s1Rs2_q   <= '0;
    end else if (clr_in) begin
      s1Valid_q <= FALSE;
    end else if (rdy_in) begin
      s1Valid_q <= rs_to_alu_ready;
      if (rs_to_alu_ready) begin
        s1Op_q  <= rs_to_alu_op;
        s1Rob_q <= rs_to_alu_rob_index;
        s1Pc_q  <= rs_to_alu_PC;
        s1Imm_q <= rs_to_alu_imm;
        s1A_q   <= s1A_d;
        s1B_q   <= s1B_d;
        s1Rs1_q <= rs_to_alu_rs1;
        s1Rs2_q <= rs_to_alu_rs2;
      end
    end
  end

  alu_branch_cmp #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_branch_cmp (
    .rs1_i   (s1Rs1_q),
    .rs2_i   (s1Rs2_q),
    .op_i    (s1Op_q),
    .taken_o (branchTaken)
  );

  always_comb begin
    result_d = '0;
    jump_d   = FALSE;
    target_d = s1Pc_q + DATA_W'(4);
    case (s1Op_q)
      OP_LUI:                     result_d = s1Imm_q;
      OP_AUIPC, OP_ADD, OP_ADDI:  result_d = s1A_q + s1B_q;
      OP_SUB:                     result_d = s1A_q - s1B_q;
      OP_SLT, OP_SLTI:
        result_d = {{(DATA_W-1){1'b0}}, ($signed(s1A_q) < $signed(s1B_q))};
      OP_SLTU, OP_SLTIU:
        result_d = {{(DATA_W-1){1'b0}}, (s1A_q < s1B_q)};
      OP_XOR, OP_XORI:            result_d = s1A_q ^ s1B_q;
      OP_OR, OP_ORI:              result_d = s1A_q | s1B_q;
      OP_AND, OP_ANDI:            result_d = s1A_q & s1B_q;
      OP_SLL, OP_SLLI:            result_d = s1A_q << s1B_q[4:0];
      OP_SRL, OP_SRLI:            result_d = s1A_q >> s1B_q[4:0];
      OP_SRA, OP_SRAI:            result_d = $unsigned($signed(s1A_q) >>> s1B_q[4:0]);
      OP_JAL: begin
        result_d = s1A_q + DATA_W'(4);
        jump_d   = TRUE;
        target_d = s1Pc_q + s1Imm_q;
      end
      // JALR's A operand is the PC (link value); the target needs the raw rs1.
      OP_JALR: begin
        result_d = s1A_q + DATA_W'(4);
        jump_d   = TRUE;
        target_d = (s1Rs1_q + s1Imm_q) & ~DATA_W'(1);
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        jump_d = branchTaken;
        if (branchTaken) target_d = s1Pc_q + s1Imm_q;
      end
      default: ;
    endcase
  end

  // Output data only changes with a real result; a flush just drops the valid.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s2Ready_q  <= FALSE;
      s2Result_q <= '0;
      s2Rob_q    <= '0;
      s2Jump_q   <= FALSE;
      s2Target_q <= '0;
    end else if (clr_in) begin
      s2Ready_q <= FALSE;
    end else if (rdy_in) begin
      s2Ready_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Result_q <= result_d;
        s2Rob_q    <= s1Rob_q;
        s2Jump_q   <= jump_d;
        s2Target_q <= target_d;
      end
    end
  end

  assign alu_ready     = s2Ready_q;
  assign alu_result    = s2Result_q;
  assign alu_rob_index = s2Rob_q;
  assign alu_jump      = s2Jump_q;
  assign alu_target_PC = s2Target_q;

endmodule

// File: tb/tb_alu_unit.sv
// Randomized bench for alu_unit: a behavioural model computes each op's
// outcome from the RV32I rules and a two-deep delay line tracks when it shows.
module tb_alu_unit;
  import alu_unit_pkg::*;

  localparam int DATA_W = 32;
  localparam int ROB_W  = 4;
  localparam int OP_W   = 6;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              rdy_in;
  logic              clr_in;
  logic              rs_to_alu_ready;
  logic [OP_W-1:0]   rs_to_alu_op;
  logic [DATA_W-1:0] rs_to_alu_rs1;
  logic [DATA_W-1:0] rs_to_alu_rs2;
  logic [ROB_W-1:0]  rs_to_alu_rob_index;
  logic [DATA_W-1:0] rs_to_alu_PC;
  logic [DATA_W-1:0] rs_to_alu_imm;
  logic              alu_ready;
  logic [DATA_W-1:0] alu_result;
  logic [ROB_W-1:0]  alu_rob_index;
  logic              alu_jump;
  logic [DATA_W-1:0] alu_target_PC;

  alu_unit #(
    .DATA_W (DATA_W),
    .ROB_W  (ROB_W),
    .OP_W   (OP_W)
  ) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .rdy_in              (rdy_in),
    .clr_in              (clr_in),
    .rs_to_alu_ready     (rs_to_alu_ready),
    .rs_to_alu_op        (rs_to_alu_op),
    .rs_to_alu_rs1       (rs_to_alu_rs1),
    .rs_to_alu_rs2       (rs_to_alu_rs2),
    .rs_to_alu_rob_index (rs_to_alu_rob_index),
    .rs_to_alu_PC        (rs_to_alu_PC),
    .rs_to_alu_imm       (rs_to_alu_imm),
    .alu_ready           (alu_ready),
    .alu_result          (alu_result),
    .alu_rob_index       (alu_rob_index),
    .alu_jump            (alu_jump),
    .alu_target_PC       (alu_target_PC)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] result;
    logic        jump;
    logic [31:0] target;
    logic [3:0]  rob;
  } expT;

  int  compareCount  = 0;
  int  mismatchCount = 0;
  logic m1Valid;
  logic moutReady;
  expT  m1Exp;
  expT  moutExp;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Straight from the RV32I semantics on the raw rs1/rs2/imm/PC values.
  function automatic expT refCompute(input logic [5:0] op, input logic [31:0] rs1,
                                     input logic [31:0] rs2, input logic [31:0] pc,
                                     input logic [31:0] imm, input logic [3:0] rob);
    expT  e;
    logic isBr;
    logic take;
    e.result = 32'h0;
    e.jump   = 1'b0;
    e.target = pc + 32'd4;
    e.rob    = rob;
    isBr     = 1'b0;
    take     = 1'b0;
    case (op)
      OP_LUI:   e.result = imm;
      OP_AUIPC: e.result = pc + imm;
      OP_ADD:   e.result = rs1 + rs2;
      OP_ADDI:  e.result = rs1 + imm;
      OP_SUB:   e.result = rs1 - rs2;
      OP_SLT:   e.result = ($signed(rs1) < $signed(rs2)) ? 32'd1 : 32'd0;
      OP_SLTI:  e.result = ($signed(rs1) < $signed(imm)) ? 32'd1 : 32'd0;
      OP_SLTU:  e.result = (rs1 < rs2) ? 32'd1 : 32'd0;
      OP_SLTIU: e.result = (rs1 < imm) ? 32'd1 : 32'd0;
      OP_XOR:   e.result = rs1 ^ rs2;
      OP_XORI:  e.result = rs1 ^ imm;
      OP_OR:    e.result = rs1 | rs2;
      OP_ORI:   e.result = rs1 | imm;
      OP_AND:   e.result = rs1 & rs2;
      OP_ANDI:  e.result = rs1 & imm;
      OP_SLL:   e.result = rs1 << rs2[4:0];
      OP_SLLI:  e.result = rs1 << imm[4:0];
      OP_SRL:   e.result = rs1 >> rs2[4:0];
      OP_SRLI:  e.result = rs1 >> imm[4:0];
      OP_SRA:   e.result = $unsigned($signed(rs1) >>> rs2[4:0]);
      OP_SRAI:  e.result = $unsigned($signed(rs1) >>> imm[4:0]);
      OP_JAL: begin
        e.result = pc + 32'd4;
        e.jump   = 1'b1;
        e.target = pc + imm;
      end
      OP_JALR: begin
        e.result = pc + 32'd4;
        e.jump   = 1'b1;
        e.target = (rs1 + imm) & 32'hFFFF_FFFE;
      end
      OP_BEQ:  begin isBr = 1'b1; take = (rs1 == rs2); end
      OP_BNE:  begin isBr = 1'b1; take = (rs1 != rs2); end
      OP_BLT:  begin isBr = 1'b1; take = ($signed(rs1) < $signed(rs2)); end
      OP_BGE:  begin isBr = 1'b1; take = !($signed(rs1) < $signed(rs2)); end
      OP_BLTU: begin isBr = 1'b1; take = (rs1 < rs2); end
      OP_BGEU: begin isBr = 1'b1; take = !(rs1 < rs2); end
      default: ;
    endcase
    if (isBr) begin
      e.jump = take;
      if (take) e.target = pc + imm;
    end
    return e;
  endfunction

  function automatic logic [31:0] pickVal();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic modelReset();
    m1Valid   = 1'b0;
    moutReady = 1'b0;
    m1Exp     = '{result: 32'h0, jump: 1'b0, target: 32'h0, rob: 4'h0};
    moutExp   = '{result: 32'h0, jump: 1'b0, target: 32'h0, rob: 4'h0};
  endtask

  task automatic modelUpdate();
    if (!rst_in) begin
      modelReset();
    end else if (clr_in) begin
      m1Valid   = 1'b0;
      moutReady = 1'b0;
    end else if (rdy_in) begin
      moutReady = m1Valid;
      if (m1Valid) moutExp = m1Exp;
      m1Valid = rs_to_alu_ready;
      if (rs_to_alu_ready)
        m1Exp = refCompute(rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_PC,
                           rs_to_alu_imm, rs_to_alu_rob_index);
    end
  endtask

  task automatic compareAll();
    checkOutput("ready", 32'(alu_ready), 32'(moutReady));
    if (moutReady) begin
      checkOutput("rob", 32'(alu_rob_index), 32'(moutExp.rob));
      checkOutput("result", alu_result, moutExp.result);
      checkOutput("jump", 32'(alu_jump), 32'(moutExp.jump));
      checkOutput("target", alu_target_PC, moutExp.target);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"}, 32'(alu_ready), 32'h0);
    checkOutput({tag, "_result"}, alu_result, 32'h0);
    checkOutput({tag, "_rob"}, 32'(alu_rob_index), 32'h0);
    checkOutput({tag, "_jump"}, 32'(alu_jump), 32'h0);
    checkOutput({tag, "_target"}, alu_target_PC, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk_in);
    modelUpdate();
    #1;
    compareAll();
  endtask

  task automatic applyStimulus(input logic valid, input logic [5:0] op, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [31:0] pc,
                               input logic [31:0] imm, input logic [3:0] rob);
    rs_to_alu_ready     = valid;
    rs_to_alu_op        = op;
    rs_to_alu_rs1       = rs1;
    rs_to_alu_rs2       = rs2;
    rs_to_alu_PC        = pc;
    rs_to_alu_imm       = imm;
    rs_to_alu_rob_index = rob;
  endtask

  task automatic idle();
    rs_to_alu_ready = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    clr_in = 1'b0;
    applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0);
    modelReset();
    #1 rst_in = 1'b0;
    #2 checkAllZero("reset");
    #1 rst_in = 1'b1;
    tick();
    tick();

    applyStimulus(1'b1, OP_ADDI, 32'h7FFF_FFFF, 32'h0, 32'h40, 32'h1, 4'd3);
    tick();
    idle();
    tick();
    checkOutput("addi_ready", 32'(alu_ready), 32'h1);
    checkOutput("addi_result", alu_result, 32'h8000_0000);
    checkOutput("addi_rob", 32'(alu_rob_index), 32'd3);
    checkOutput("addi_jump", 32'(alu_jump), 32'h0);
    checkOutput("addi_target", alu_target_PC, 32'h44);

    applyStimulus(1'b1, OP_SRA, 32'h8000_0000, 32'h24, 32'h80, 32'h0, 4'd4);
    tick();
    applyStimulus(1'b1, OP_SLTU, 32'h1, 32'hFFFF_FFFF, 32'h84, 32'h0, 4'd5);
    tick();
    idle();
    checkOutput("sra_ready", 32'(alu_ready), 32'h1);
    checkOutput("sra_result", alu_result, 32'hF800_0000);
    tick();
    checkOutput("sltu_ready", 32'(alu_ready), 32'h1);
    checkOutput("sltu_result", alu_result, 32'h1);

    applyStimulus(1'b1, OP_BLT, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'hFFFF_FFF8, 4'd6);
    tick();
    applyStimulus(1'b1, OP_BLTU, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'hFFFF_FFF8, 4'd7);
    tick();
    idle();
    checkOutput("blt_result", alu_result, 32'h0);
    checkOutput("blt_jump", 32'(alu_jump), 32'h1);
    checkOutput("blt_target", alu_target_PC, 32'hF8);
    tick();
    checkOutput("bltu_jump", 32'(alu_jump), 32'h0);
    checkOutput("bltu_target", alu_target_PC, 32'h104);

    applyStimulus(1'b1, OP_JALR, 32'h1003, 32'h0, 32'h200, 32'h4, 4'd8);
    tick();
    idle();
    tick();
    checkOutput("jalr_result", alu_result, 32'h204);
    checkOutput("jalr_jump", 32'(alu_jump), 32'h1);
    checkOutput("jalr_target", alu_target_PC, 32'h1006);

    applyStimulus(1'b1, OP_ADD, 32'h10, 32'h20, 32'h300, 32'h0, 4'd1);
    tick();
    applyStimulus(1'b1, OP_SUB, 32'h10, 32'h20, 32'h304, 32'h0, 4'd2);
    tick();
    applyStimulus(1'b1, OP_XOR, 32'h10, 32'h20, 32'h308, 32'h0, 4'd3);
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0;
    idle();
    checkOutput("clr_ready_a", 32'(alu_ready), 32'h0);
    tick();
    checkOutput("clr_ready_b", 32'(alu_ready), 32'h0);
    applyStimulus(1'b1, OP_OR, 32'hF0, 32'h0F, 32'h30C, 32'h0, 4'd9);
    tick();
    idle();
    tick();
    checkOutput("postclr_ready", 32'(alu_ready), 32'h1);
    checkOutput("postclr_result", alu_result, 32'hFF);

    applyStimulus(1'b1, OP_ADD, 32'd5, 32'd7, 32'h400, 32'h0, 4'd6);
    tick();
    idle();
    tick();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_ready", 32'(alu_ready), 32'h1);
      checkOutput("stall_result", alu_result, 32'd12);
      checkOutput("stall_rob", 32'(alu_rob_index), 32'd6);
    end
    rdy_in = 1'b1;
    tick();
    checkOutput("release_ready", 32'(alu_ready), 32'h0);
    tick();

    // A flush must land even while the pipe is frozen.
    applyStimulus(1'b1, OP_AND, 32'hFF, 32'h0F, 32'h500, 32'h0, 4'd10);
    tick();
    idle();
    rdy_in = 1'b0;
    clr_in = 1'b1;
    tick();
    rdy_in = 1'b1;
    clr_in = 1'b0;
    tick();
    checkOutput("clrstall_ready", 32'(alu_ready), 32'h0);

    applyStimulus(1'b1, OP_LUI, 32'h0, 32'h0, 32'h600, 32'hABCD_E000, 4'd11);
    tick();
    applyStimulus(1'b1, OP_AUIPC, 32'h0, 32'h0, 32'h604, 32'h1000, 4'd12);
    tick();
    #1 rst_in = 1'b0;
    #1 checkAllZero("midrst");
    modelReset();
    idle();
    tick();
    #2 rst_in = 1'b1;
    tick();

    for (int i = 0; i < 400; i++) begin
      rdy_in = ($urandom_range(0, 7) != 0);
      clr_in = ($urandom_range(0, 24) == 0);
      applyStimulus(($urandom_range(0, 3) != 0), 6'($urandom_range(0, 31)), pickVal(),
                    pickVal(), $urandom & 32'hFFFF_FFFC, pickVal(),
                    4'($urandom_range(1, 15)));
      tick();
    end

    rdy_in = 1'b1;
    clr_in = 1'b0;
    idle();
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
# alu_unit

Two-stage pipelined integer execution unit on the consumer end of the reservation-station-to-ALU interface. Accepts at most one ready RV32I non-memory op per cycle with no backpressure, computes result and control-flow outcome, and broadcasts on the ALU result bus. That bus feeds the reservation station wakeup, the load/store buffer and the ROB.

## Interface
Parameters:
- DATA_W, 32, operand/result/PC width
- ROB_W, 4, ROB index width; index 0 is reserved as "no dependency" and is never issued
- OP_W, 6, width of op enumeration

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global enable; low freezes every register
- clr_in  in  1  synchronous flush on misprediction; active high
- rs_to_alu_ready  in  1  input op valid this cycle
- rs_to_alu_op  in  OP_W  op enum
- rs_to_alu_rs1  in  DATA_W  rs1 value
- rs_to_alu_rs2  in  DATA_W  rs2 value
- rs_to_alu_rob_index  in  ROB_W  destination ROB entry
- rs_to_alu_PC  in  DATA_W  instruction PC
- rs_to_alu_imm  in  DATA_W  sign-extended immediate
- alu_ready  out  1  result valid, one cycle per op
- alu_result  out  DATA_W  value written to rd
- alu_rob_index  out  ROB_W  tag of result
- alu_jump  out  1  actual control transfer taken
- alu_target_PC  out  DATA_W  actual next PC: taken target or PC+4

## Operation
- S1, the operand stage, registers valid, op, rob_index, PC and imm. It also registers operands A and B, muxed as follows:
  - A = PC for AUIPC/JAL/JALR-link, otherwise rs1.
  - B = imm for I-type/U-type, otherwise rs2.
  - For branches, S1 additionally keeps rs1 and rs2 for comparison.
- S2, the execute stage, computes and registers all outputs from S1.
- Op results:
  - LUI: imm.
  - AUIPC: PC+imm.
  - ADD/ADDI: A+B. SUB: A−B, wraps mod 2^32.
  - SLT/SLTI: signed compare. SLTU/SLTIU: unsigned compare. Result is 0 or 1.
  - XOR/OR/AND and their immediate forms: bitwise.
  - SLL/SRL/SRA and their immediate forms: shift amount is B[4:0]. SRA is arithmetic.
  - JAL: result PC+4, jump=1, target PC+imm.
  - JALR: result PC+4, jump=1, target (rs1+imm) & ~1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: result 0. jump = condition. Target = PC+imm if taken, else PC+4.
  - Non-control ops: jump=0, target PC+4.
- An unknown op enum still produces alu_ready, with result 0 and jump 0.
- The unit never stalls the producer; every valid input is accepted while rdy_in=1.

## Timing
- Reset (rst_in=0, async): S1/S2 valid=0. alu_ready=0, alu_result=0, alu_rob_index=0, alu_jump=0, alu_target_PC=0.
- Latency: input valid in cycle N produces alu_ready in cycle N+2 (visible after the second rising edge). Throughput is 1/cycle.
- alu_ready is high exactly one cycle per accepted op, unless that cycle is frozen by rdy_in=0.
- rdy_in=0: no register updates. Outputs hold, including alu_ready=1 if it was 1. The input is not sampled; the producer also holds, so there is no loss or duplication.
- clr_in=1 (while rdy_in=1):
  - Both stage valids are cleared and alu_ready=0 next cycle.
  - An input valid in the same cycle is discarded.
  - An op in S2 whose output is currently showing completes its current cycle only.
- clr_in with rdy_in=0: clr wins and the flush still occurs.
- Reset during operation: immediate async clear regardless of clock.

## Structure
- The shared package/define file holds:
  - the op enum (OPENUM_TYPE, shared with decoder and reservation station);
  - DATA_TYPE, ADDR_TYPE and ROB_INDEX_TYPE widths;
  - TRUE/FALSE.
- One combinational sub-module, alu_branch_cmp: takes rs1, rs2 and op, and outputs taken. It is reused by any future branch unit.
- The rest is two always blocks, one per stage, with async-reset flops.

## Test plan
- ADDI: rs1=0x7FFFFFFF, imm=1, rob=3 in cycle N -> cycle N+2: ready=1, result=0x80000000, rob=3, jump=0, target=PC+4.
- Back-to-back SRA rs1=0x80000000 rs2=0x24, then SLTU rs1=1 rs2=0xFFFFFFFF -> consecutive ready cycles with results 0xF8000000 then 1.
- BLT rs1=0xFFFFFFFF rs2=1, PC=0x100, imm=−8 -> jump=1, target=0xF8, result=0. The same op with BLTU -> jump=0, target=0x104.
- JALR rs1=0x1003, imm=4, PC=0x200 -> result=0x204, jump=1, target=0x1006.
- Two ops in flight, clr_in pulsed one cycle -> no alu_ready in the following two cycles. A new op after clr returns normally two cycles later.
- rdy_in low for 3 cycles with alu_ready=1 -> the outputs are held unchanged. No extra ready pulse appears after release. rst_in asserted mid-stream -> all outputs zero immediately.
